// File: rtl/data_memory_bus_if.sv
// Request/response bus between the load-store unit and data_memory_bus.
// master: requester (MEM stage / LSU), drives the request fields.
// slave : data_memory_bus, drives req_ready and the response fields.
//   req_valid/req_ready  request handshake
//   MemWrite/MemRead     store/load select (neither = no-op)
//   Size                 00 byte, 01 half, 10 word, 11 doubleword
//   Unsigned             zero-extend loads instead of sign-extend
//   Address/WriteData    byte address, right-aligned store data
//   resp_valid           one-cycle response strobe
//   ReadData/error       load result and access fault, valid with resp_valid
interface data_memory_bus_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  MemWrite;
    logic                  MemRead;
    logic [1:0]            Size;
    logic                  Unsigned;
    logic [31:0]           Address;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  error;

    modport master (
        output req_valid, MemWrite, MemRead, Size, Unsigned, Address, WriteData,
        input  req_ready, resp_valid, ReadData, error
    );

    modport slave (
        input  req_valid, MemWrite, MemRead, Size, Unsigned, Address, WriteData,
        output req_ready, resp_valid, ReadData, error
    );
endinterface

// File: rtl/data_memory_bus.sv
// Byte-addressable data memory for the MIPS datapath, mapped at BASE_ADDRESS.
// Supports byte/half/word(/double at 64-bit) loads and stores with sign or
// zero extension, a configurable latency behind a valid/ready handshake, and
// flags misaligned, out-of-range and malformed requests.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; returns the FSM to IDLE and drops any
//          not-yet-committed store (memory contents are kept)
//   bus    data_memory_bus_if slave modport (request and response signals)
module data_memory_bus #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
    parameter int unsigned LATENCY      = 1
) (
    input  logic             clk,
    input  logic             reset,
    data_memory_bus_if.slave bus
);

    localparam int unsigned LANES  = DATA_WIDTH / 8;
    localparam int unsigned OFS    = $clog2(LANES);
    localparam int unsigned IDX_W  = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam int unsigned WIDX_W = 32 - OFS;
    localparam int unsigned CNT_W  = 3;

    // Elaboration-time parameter guards
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : gBadWidth
        $error("data_memory_bus: DATA_WIDTH must be 32 or 64");
    end
    if (LATENCY > 7) begin : gBadLatency
        $error("data_memory_bus: LATENCY must be in 0..7");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Decoded request, captured on accept so the requester may move on
    typedef struct packed {
        logic                  isRead;
        logic                  isWrite;
        logic                  err;
        logic                  uns;
        logic [1:0]            size;
        logic [IDX_W-1:0]      idx;
        logic [OFS-1:0]        lane;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    state_t                state;
    state_t                nextState;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      nextCount;
    req_t                  holdReq;
    req_t                  nextHoldReq;
    req_t                  inReq;
    req_t                  curReq;
    logic                  enterResp;
    logic                  memWe;

    logic                  reqReadyQ;
    logic                  respValidQ;
    logic                  errorQ;
    logic [DATA_WIDTH-1:0] readDataQ;
    logic                  nextReqReady;
    logic                  nextRespValid;
    logic                  nextError;
    logic [DATA_WIDTH-1:0] nextReadData;

    logic [32:0]           offset;
    logic [WIDX_W-1:0]     wordIdx;
    logic [OFS-1:0]        laneIn;
    logic                  outOfRange;
    logic                  misaligned;
    logic                  badSize;
    logic                  conflict;

    logic [DATA_WIDTH-1:0] rawWord;
    logic [DATA_WIDTH-1:0] laneWord;
    logic [DATA_WIDTH-1:0] sizeMask;
    logic [DATA_WIDTH-1:0] topBit;
    logic [DATA_WIDTH-1:0] loadData;
    logic [DATA_WIDTH-1:0] storeData;
    logic [6:0]            nBits;
    logic [LANES-1:0]      laneMask;
    logic [LANES-1:0]      byteEn;
    logic                  signBit;

    // Address decode and fault classification of the incoming request
    always_comb begin
        offset     = {1'b0, bus.Address} - {1'b0, BASE_ADDRESS};
        wordIdx    = offset[31:OFS];
        laneIn     = offset[OFS-1:0];
        // Bit 32 set means the address lies below the base
        outOfRange = offset[32] || (wordIdx >= WIDX_W'(MEMORY_DEPTH));
        misaligned = 1'b0;
        case (bus.Size)
            2'b01:   misaligned = laneIn[0];
            2'b10:   misaligned = |laneIn[1:0];
            2'b11:   misaligned = |laneIn;
            default: misaligned = 1'b0;
        endcase
        badSize  = (bus.Size == 2'b11) && (DATA_WIDTH == 32);
        conflict = bus.MemRead && bus.MemWrite;

        inReq.isRead  = bus.MemRead;
        inReq.isWrite = bus.MemWrite;
        // A no-op touches nothing, so it never faults
        inReq.err     = (bus.MemRead || bus.MemWrite) &&
                        (outOfRange || misaligned || badSize || conflict);
        inReq.uns     = bus.Unsigned;
        inReq.size    = bus.Size;
        inReq.idx     = wordIdx[IDX_W-1:0];
        inReq.lane    = laneIn;
        inReq.wdata   = bus.WriteData;
    end

    // With LATENCY=0 the request completes on its accept edge, so the live
    // inputs are used while IDLE; otherwise the captured copy is used.
    assign curReq = (state == IDLE) ? inReq : holdReq;

    // Lane selection, extension and byte-enable generation
    always_comb begin
        rawWord  = mem[curReq.idx];
        laneWord = rawWord >> {curReq.lane, 3'b000};
        nBits    = 7'(8) << curReq.size;
        // Shifting by the full width yields 0, so minus one gives all ones
        sizeMask = (DATA_WIDTH'(1) << nBits) - DATA_WIDTH'(1);
        topBit   = sizeMask & ~(sizeMask >> 1);
        signBit  = |(laneWord & topBit);
        loadData = (laneWord & sizeMask) |
                   ((!curReq.uns && signBit) ? ~sizeMask : '0);

        laneMask = '0;
        case (curReq.size)
            2'b00:   laneMask = LANES'(1);
            2'b01:   laneMask = LANES'(3);
            2'b10:   laneMask = LANES'(15);
            default: laneMask = '1;
        endcase
        byteEn    = laneMask << curReq.lane;
        storeData = curReq.wdata << {curReq.lane, 3'b000};
    end

    // Next-state, counter and registered-output logic
    always_comb begin
        nextState     = state;
        nextCount     = count;
        nextHoldReq   = holdReq;
        enterResp     = 1'b0;
        nextReqReady  = 1'b0;
        nextRespValid = 1'b0;
        nextError     = 1'b0;
        nextReadData  = '0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    nextHoldReq = inReq;
                    if (LATENCY == 0) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = WAIT;
                        nextCount = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (count == '0) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end else begin
                    nextCount = count - CNT_W'(1);
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        nextReqReady  = (nextState == IDLE);
        nextRespValid = enterResp;
        nextError     = enterResp && curReq.err;
        if (enterResp && curReq.isRead && !curReq.err) begin
            nextReadData = loadData;
        end
    end

    // Store commits on the edge that enters RESP
    assign memWe = enterResp && curReq.isWrite && !curReq.err && !reset;

    // State, request capture and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            holdReq    <= '0;
            reqReadyQ  <= 1'b1;
            respValidQ <= 1'b0;
            errorQ     <= 1'b0;
            readDataQ  <= '0;
        end else begin
            state      <= nextState;
            count      <= nextCount;
            holdReq    <= nextHoldReq;
            reqReadyQ  <= nextReqReady;
            respValidQ <= nextRespValid;
            errorQ     <= nextError;
            readDataQ  <= nextReadData;
        end
    end

    // Data array with per-lane write enables; never reset
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (byteEn[i]) begin
                    mem[curReq.idx][8*i +: 8] <= storeData[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = reqReadyQ;
    assign bus.resp_valid = respValidQ;
    assign bus.error      = errorQ;
    assign bus.ReadData   = readDataQ;

endmodule

// File: tb/tb_data_memory_bus.sv
// Self-checking bench for data_memory_bus: scoreboard of expected responses
// against a monitor of observed ones, plus cycle-exact handshake checks on
// LATENCY=3 and LATENCY=0 instances.
module tb_data_memory_bus;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 1024;
    localparam int          LAT   = 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   applied = 0;
    int   fails = 0;
    int   lastAcc = 0;
    rec_t expQ[$];
    rec_t obsQ[$];
    rec_t monRec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_bus_if #(.DATA_WIDTH(32)) bus ();
    data_memory_bus_if #(.DATA_WIDTH(32)) bus3 ();
    data_memory_bus_if #(.DATA_WIDTH(32)) bus0 ();

    data_memory_bus #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE), .LATENCY(LAT))
        dut (.clk(clk), .reset(rst), .bus(bus));
    data_memory_bus #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE), .LATENCY(3))
        dut3 (.clk(clk), .reset(rst), .bus(bus3));
    data_memory_bus #(.DATA_WIDTH(32), .MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE), .LATENCY(0))
        dut0 (.clk(clk), .reset(rst), .bus(bus0));

    // Response monitor for the main instance
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            monRec.data = bus.ReadData;
            monRec.err  = bus.error;
            monRec.cyc  = cyc;
            obsQ.push_back(monRec);
        end
    end

    // Drive one request, wait for accept, then scramble the inputs.
    // The response is expected LAT edges after the accept edge.
    task automatic issue(input logic wr, input logic rd, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] expData, input logic expErr, input bit push);
        int   n;
        rec_t e;
        @(negedge clk);
        bus.MemWrite  = wr;
        bus.MemRead   = rd;
        bus.Size      = sz;
        bus.Unsigned  = uns;
        bus.Address   = addr;
        bus.WriteData = wd;
        bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            applied++;
            fails++;
            $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        lastAcc       = cyc;
        bus.req_valid = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.Size      = 2'($urandom);
        bus.Unsigned  = 1'($urandom);
        bus.Address   = $urandom;
        bus.WriteData = $urandom;
        if (push) begin
            e.data = expData;
            e.err  = expErr;
            e.cyc  = lastAcc + LAT;
            expQ.push_back(e);
        end
    endtask

    // Bounded wait until every expected response has been observed
    task automatic drain();
        int n;
        n = 0;
        while (obsQ.size() < expQ.size() && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (obsQ.size() < expQ.size()) begin
            applied++;
            fails++;
            $display("FAIL resp_timeout: got %0d responses required %0d", obsQ.size(), expQ.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        applied += 6;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset req_ready: got %b required 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset resp_valid: got %b required 0", bus.resp_valid); end
        if (bus.error !== 1'b0) begin fails++; $display("FAIL reset error: got %b required 0", bus.error); end
        if (bus.ReadData !== 32'h0) begin fails++; $display("FAIL reset ReadData: got %h required 0", bus.ReadData); end
        if (bus3.req_ready !== 1'b1) begin fails++; $display("FAIL reset req_ready3: got %b required 1", bus3.req_ready); end
        if (bus0.req_ready !== 1'b1) begin fails++; $display("FAIL reset req_ready0: got %b required 1", bus0.req_ready); end
        rst = 1'b0;
        @(negedge clk);
        applied++;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL post_reset req_ready: got %b required 1", bus.req_ready); end
    endtask

    task automatic test_word();
        rec_t e, o;
        issue(1, 0, 2'b10, 0, BASE + 4, 32'hDEAD_BEEF, 32'h0, 0, 1);
        issue(0, 1, 2'b10, 0, BASE + 4, 32'h0, 32'hDEAD_BEEF, 0, 1);
        drain();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() == 0) begin
                applied++; fails++;
                $display("FAIL word missing: no response, required data %h", e.data);
            end else begin
                o = obsQ.pop_front();
                applied += 3;
                if (o.data !== e.data) begin fails++; $display("FAIL word data: got %h required %h", o.data, e.data); end
                if (o.err !== e.err) begin fails++; $display("FAIL word error: got %b required %b", o.err, e.err); end
                if (o.cyc !== e.cyc) begin fails++; $display("FAIL word latency: resp cycle %0d required %0d", o.cyc, e.cyc); end
            end
        end
    endtask

    task automatic test_byte_lanes();
        rec_t e, o;
        issue(1, 0, 2'b10, 0, BASE,     32'h0,         32'h0,         0, 1);
        issue(1, 0, 2'b00, 0, BASE + 2, 32'hFFFF_FF80, 32'h0,         0, 1);
        issue(0, 1, 2'b10, 0, BASE,     32'h0,         32'h0080_0000, 0, 1);
        issue(0, 1, 2'b00, 0, BASE + 2, 32'h0,         32'hFFFF_FF80, 0, 1);
        issue(0, 1, 2'b00, 1, BASE + 2, 32'h0,         32'h0000_0080, 0, 1);
        issue(1, 0, 2'b00, 0, BASE + 3, 32'h1234_567F, 32'h0,         0, 1);
        issue(0, 1, 2'b00, 0, BASE + 3, 32'h0,         32'h0000_007F, 0, 1);
        issue(0, 1, 2'b10, 0, BASE,     32'h0,         32'h7F80_0000, 0, 1);
        drain();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() == 0) begin
                applied++; fails++;
                $display("FAIL byte missing: no response, required data %h", e.data);
            end else begin
                o = obsQ.pop_front();
                applied += 3;
                if (o.data !== e.data) begin fails++; $display("FAIL byte data: got %h required %h", o.data, e.data); end
                if (o.err !== e.err) begin fails++; $display("FAIL byte error: got %b required %b", o.err, e.err); end
                if (o.cyc !== e.cyc) begin fails++; $display("FAIL byte latency: resp cycle %0d required %0d", o.cyc, e.cyc); end
            end
        end
    endtask

    task automatic test_halfword();
        rec_t e, o;
        issue(1, 0, 2'b01, 0, BASE + 6, 32'h1234_8001, 32'h0,         0, 1);
        issue(0, 1, 2'b01, 0, BASE + 6, 32'h0,         32'hFFFF_8001, 0, 1);
        issue(0, 1, 2'b01, 1, BASE + 6, 32'h0,         32'h0000_8001, 0, 1);
        issue(0, 1, 2'b01, 0, BASE + 4, 32'h0,         32'hFFFF_BEEF, 0, 1);
        issue(0, 1, 2'b01, 1, BASE + 4, 32'h0,         32'h0000_BEEF, 0, 1);
        issue(0, 1, 2'b10, 0, BASE + 4, 32'h0,         32'h8001_BEEF, 0, 1);
        drain();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() == 0) begin
                applied++; fails++;
                $display("FAIL half missing: no response, required data %h", e.data);
            end else begin
                o = obsQ.pop_front();
                applied += 3;
                if (o.data !== e.data) begin fails++; $display("FAIL half data: got %h required %h", o.data, e.data); end
                if (o.err !== e.err) begin fails++; $display("FAIL half error: got %b required %b", o.err, e.err); end
                if (o.cyc !== e.cyc) begin fails++; $display("FAIL half latency: resp cycle %0d required %0d", o.cyc, e.cyc); end
            end
        end
    endtask

    task automatic test_errors();
        rec_t e, o;
        issue(0, 1, 2'b10, 0, BASE + 2,          32'h0,         32'h0, 1, 1);
        issue(1, 0, 2'b01, 0, BASE + 1,          32'h0000_FFFF, 32'h0, 1, 1);
        issue(1, 0, 2'b10, 0, BASE + 5,          32'hFFFF_FFFF, 32'h0, 1, 1);
        issue(1, 0, 2'b10, 0, 32'h1000_FFFC,     32'hFFFF_FFFF, 32'h0, 1, 1);
        issue(0, 1, 2'b00, 0, 32'h1000_FFFF,     32'h0,         32'h0, 1, 1);
        issue(0, 1, 2'b10, 0, BASE + 4 * DEPTH,  32'h0,         32'h0, 1, 1);
        issue(1, 0, 2'b10, 0, BASE + 4 * DEPTH,  32'hFFFF_FFFF, 32'h0, 1, 1);
        issue(0, 1, 2'b11, 0, BASE,              32'h0,         32'h0, 1, 1);
        issue(1, 1, 2'b10, 0, BASE + 4,          32'h5555_5555, 32'h0, 1, 1);
        issue(0, 0, 2'b10, 0, BASE + 4,          32'h5555_5555, 32'h0, 0, 1);
        issue(1, 0, 2'b10, 0, BASE + 4 * DEPTH - 4, 32'h1122_3344, 32'h0, 0, 1);
        issue(0, 1, 2'b10, 0, BASE + 4 * DEPTH - 4, 32'h0,      32'h1122_3344, 0, 1);
        issue(0, 1, 2'b10, 0, BASE + 4,          32'h0,         32'h8001_BEEF, 0, 1);
        issue(0, 1, 2'b10, 0, BASE,              32'h0,         32'h7F80_0000, 0, 1);
        drain();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() == 0) begin
                applied++; fails++;
                $display("FAIL err missing: no response, required data %h", e.data);
            end else begin
                o = obsQ.pop_front();
                applied += 3;
                if (o.data !== e.data) begin fails++; $display("FAIL err data: got %h required %h", o.data, e.data); end
                if (o.err !== e.err) begin fails++; $display("FAIL err error: got %b required %b", o.err, e.err); end
                if (o.cyc !== e.cyc) begin fails++; $display("FAIL err latency: resp cycle %0d required %0d", o.cyc, e.cyc); end
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        int   a1, a2;
        issue(0, 1, 2'b10, 0, BASE + 4, 32'h0, 32'h8001_BEEF, 0, 1);
        a1 = lastAcc;
        issue(0, 1, 2'b10, 0, BASE,     32'h0, 32'h7F80_0000, 0, 1);
        a2 = lastAcc;
        applied++;
        if (a2 - a1 !== LAT + 2) begin fails++; $display("FAIL b2b spacing: got %0d cycles required %0d", a2 - a1, LAT + 2); end
        drain();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() == 0) begin
                applied++; fails++;
                $display("FAIL b2b missing: no response, required data %h", e.data);
            end else begin
                o = obsQ.pop_front();
                applied += 3;
                if (o.data !== e.data) begin fails++; $display("FAIL b2b data: got %h required %h", o.data, e.data); end
                if (o.err !== e.err) begin fails++; $display("FAIL b2b error: got %b required %b", o.err, e.err); end
                if (o.cyc !== e.cyc) begin fails++; $display("FAIL b2b latency: resp cycle %0d required %0d", o.cyc, e.cyc); end
            end
        end
        @(negedge clk);
        applied += 3;
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL idle resp_valid: got %b required 0", bus.resp_valid); end
        if (bus.ReadData !== 32'h0) begin fails++; $display("FAIL idle ReadData: got %h required 0", bus.ReadData); end
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL idle req_ready: got %b required 1", bus.req_ready); end
    endtask

    task automatic test_handshake();
        logic [31:0] expData;
        // LATENCY=3 with req_valid held high across WAIT and RESP
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            bus3.MemWrite  = (op == 0);
            bus3.MemRead   = (op == 1);
            bus3.Size      = 2'b10;
            bus3.Unsigned  = 1'b0;
            bus3.Address   = BASE + 8;
            bus3.WriteData = 32'hA5A5_5A5A;
            bus3.req_valid = 1'b1;
            applied++;
            if (bus3.req_ready !== 1'b1) begin fails++; $display("FAIL hs3 ready_before: got %b required 1", bus3.req_ready); end
            @(posedge clk);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                expData = (k == 3 && op == 1) ? 32'hA5A5_5A5A : 32'h0;
                applied += 4;
                if (bus3.req_ready !== 1'(k == 4)) begin fails++; $display("FAIL hs3 req_ready k=%0d: got %b required %b", k, bus3.req_ready, (k == 4)); end
                if (bus3.resp_valid !== 1'(k == 3)) begin fails++; $display("FAIL hs3 resp_valid k=%0d: got %b required %b", k, bus3.resp_valid, (k == 3)); end
                if (bus3.error !== 1'b0) begin fails++; $display("FAIL hs3 error k=%0d: got %b required 0", k, bus3.error); end
                if (bus3.ReadData !== expData) begin fails++; $display("FAIL hs3 ReadData k=%0d: got %h required %h", k, bus3.ReadData, expData); end
            end
            bus3.req_valid = 1'b0;
        end
        // LATENCY=0: response in the cycle right after the accept edge
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            bus0.MemWrite  = (op == 0);
            bus0.MemRead   = (op == 1);
            bus0.Size      = 2'b01;
            bus0.Unsigned  = 1'b1;
            bus0.Address   = BASE + 2;
            bus0.WriteData = 32'h0000_9234;
            bus0.req_valid = 1'b1;
            @(posedge clk);
            #1;
            bus0.req_valid = 1'b0;
            bus0.Address   = 32'h0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                expData = (k == 0 && op == 1) ? 32'h0000_9234 : 32'h0;
                applied += 3;
                if (bus0.req_ready !== 1'(k == 1)) begin fails++; $display("FAIL hs0 req_ready k=%0d: got %b required %b", k, bus0.req_ready, (k == 1)); end
                if (bus0.resp_valid !== 1'(k == 0)) begin fails++; $display("FAIL hs0 resp_valid k=%0d: got %b required %b", k, bus0.resp_valid, (k == 0)); end
                if (bus0.ReadData !== expData) begin fails++; $display("FAIL hs0 ReadData k=%0d: got %h required %h", k, bus0.ReadData, expData); end
            end
        end
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        // Store accepted, then reset while it waits: it must never commit
        issue(1, 0, 2'b10, 0, BASE, 32'h1234_5678, 32'h0, 0, 0);
        rst = 1'b1;
        #1;
        applied += 2;
        if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL midrst req_ready: got %b required 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL midrst resp_valid: got %b required 0", bus.resp_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        applied++;
        if (obsQ.size() != 0) begin fails++; $display("FAIL midrst spurious: got %0d responses required 0", obsQ.size()); end
        obsQ.delete();
        issue(0, 1, 2'b10, 0, BASE, 32'h0, 32'h7F80_0000, 0, 1);
        drain();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (obsQ.size() == 0) begin
                applied++; fails++;
                $display("FAIL midrst missing: no response, required data %h", e.data);
            end else begin
                o = obsQ.pop_front();
                applied += 3;
                if (o.data !== e.data) begin fails++; $display("FAIL midrst data: got %h required %h", o.data, e.data); end
                if (o.err !== e.err) begin fails++; $display("FAIL midrst error: got %b required %b", o.err, e.err); end
                if (o.cyc !== e.cyc) begin fails++; $display("FAIL midrst latency: resp cycle %0d required %0d", o.cyc, e.cyc); end
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0; bus.MemWrite  = 1'b0; bus.MemRead  = 1'b0; bus.Size  = 2'b10;
        bus.Unsigned   = 1'b0; bus.Address   = 32'h0; bus.WriteData  = 32'h0;
        bus3.req_valid = 1'b0; bus3.MemWrite = 1'b0; bus3.MemRead = 1'b0; bus3.Size = 2'b10;
        bus3.Unsigned  = 1'b0; bus3.Address  = 32'h0; bus3.WriteData = 32'h0;
        bus0.req_valid = 1'b0; bus0.MemWrite = 1'b0; bus0.MemRead = 1'b0; bus0.Size = 2'b10;
        bus0.Unsigned  = 1'b0; bus0.Address  = 32'h0; bus0.WriteData = 32'h0;

        test_reset();
        test_word();
        test_byte_lanes();
        test_halfword();
        test_errors();
        test_back_to_back();
        test_handshake();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_memory_bus.md
# data_memory_bus

Byte-addressable data memory for the MIPS datapath: a parametrised successor to the single-cycle word memory. It supports byte, halfword and word (plus doubleword at 64-bit width) loads and stores, with sign or zero extension, and a configurable read/write latency behind a valid/ready request and response handshake. It also flags misaligned and out-of-range accesses. It sits between the MEM stage / load-store unit and the data-segment RAM, mapped at BASE_ADDRESS.

## Interface
- DATA_WIDTH, 32: word width; 32 or 64 only. LANES = DATA_WIDTH/8; OFS = log2(LANES).
- MEMORY_DEPTH, 1024: number of words.
- BASE_ADDRESS, 32'h1001_0000: byte address of word 0.
- LATENCY, 1: wait cycles between accept and response; legal range 0..7.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- MemWrite  in  1  store request.
- MemRead  in  1  load request.
- Size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_WIDTH=64).
- Unsigned  in  1  zero-extend load (lbu/lhu); otherwise sign-extend.
- Address  in  32  byte address.
- WriteData  in  DATA_WIDTH  store data, right-aligned (low bytes significant).
- resp_valid  out  1  one-cycle response strobe.
- ReadData  out  DATA_WIDTH  load result; 0 whenever resp_valid=0.
- error  out  1  valid only with resp_valid.

## Operation
- Request is accepted on a rising edge with req_valid && req_ready. Address, Size, Unsigned, MemRead, MemWrite and WriteData are latched at that edge; the inputs may change afterwards.
- offset = Address − BASE_ADDRESS, computed in 33 bits. word index = offset >> OFS; lane = offset[OFS-1:0].
- An accepted request is an error (no write, ReadData=0, error=1) if any of the following hold:
  - Address < BASE_ADDRESS, or word index ≥ MEMORY_DEPTH.
  - The access is misaligned: half with lane[0]≠0; word with lane[1:0]≠0; double with lane≠0.
  - Size=11 with DATA_WIDTH=32.
  - MemRead and MemWrite are both set.
- Neither MemRead nor MemWrite set: no-op; response with error=0 and ReadData=0.
- Stores are little-endian. Only the lanes lane..lane+bytes−1 are written, from WriteData[8*bytes−1:0]; other lanes keep their contents.
- Loads select the same lanes and place them right-aligned in ReadData. Unsigned=0 sign-extends from the top selected bit; Unsigned=1 zero-extends. Word loads at DATA_WIDTH=64 extend the same way.
- Memory contents are not initialised or cleared by reset.

## Timing
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: counter runs from LATENCY−1 down to 0.
  - RESP: resp_valid=1 for exactly one cycle.
- Transitions:
  - IDLE→WAIT on accept when LATENCY≥1.
  - IDLE→RESP on accept when LATENCY=0.
  - WAIT→RESP when the counter is 0.
  - RESP→IDLE unconditionally; there is no response back-pressure.
- resp_valid rises LATENCY+1 cycles after the accept edge. Throughput is one request per LATENCY+2 cycles.
- The store commits on the edge that enters RESP. A load in RESP reads the array combinationally, so a load issued after a store sees the stored data.
- req_ready=0 in WAIT and RESP. req_valid asserted there is ignored and must be held by the requester.
- Reset, including mid-operation: the FSM goes to IDLE at once. The counter clears and a not-yet-committed store is discarded. Reset values: req_ready=1, resp_valid=0, error=0, ReadData=0.

## Test plan
- Word store then load, LATENCY=1: sw 32'hDEADBEEF @32'h1001_0004, then lw @32'h1001_0004 → resp_valid 2 cycles after each accept, ReadData=32'hDEADBEEF, error=0.
- Byte lanes: word 0=32'h0; sb 8'h80 @32'h1001_0002 → word 0=32'h0080_0000. lb at that address → 32'hFFFF_FF80; lbu → 32'h0000_0080.
- Halfword: sh 16'h8001 @32'h1001_0006 → lh returns 32'hFFFF_8001, lhu returns 32'h0000_8001. The low half of word 1 is unchanged.
- Errors: lw @32'h1001_0002 (misaligned), sw @32'h1000_FFFC (below base) and lw @BASE+4*MEMORY_DEPTH (above range) → each gives error=1, ReadData=0, and no memory change.
- Handshake: LATENCY=3 with req_valid held high → req_ready low for 4 cycles, resp_valid 4 cycles after accept; LATENCY=0 → response the cycle after accept.
- Reset in WAIT during sw 32'h1234_5678 @BASE → returns to IDLE with no response; a later lw @BASE returns the old contents.
